// File: rtl/mem_arbiter_pkg.sv
// mem_sys_pkg: shared state, owner and block geometry constants for the memory arbiter.
package mem_sys_pkg;
  localparam int BLOCK_WORDS = 8;
  localparam int MEM_LATENCY = 4;
  localparam int OFS_W = $clog2(BLOCK_WORDS);
  localparam logic [1:0] ST_DRAIN = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;
endpackage

// File: rtl/mem_arbiter_word_counter.sv
// word_counter: block-word index counter with clear, enable and terminal count.
module word_counter
  import mem_sys_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [OFS_W-1:0] cnt,
  output logic             tc
);
  always_ff @(posedge clk)
    if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = &cnt;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares main memory between I-cache fills and D-cache fills/stores.
module mem_arbiter
  import mem_sys_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              i_grant,
  output logic              d_grant,
  output logic              i_done,
  output logic              d_done,
  output logic              fill_valid,
  output logic [DATA_W-1:0] fill_data,
  output logic [OFS_W-1:0]  fill_word,
  output logic              fill_owner,
  output logic              busy,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_data_valid
);
  logic [1:0] state, state_nx;
  logic [2:0] drain_cnt;
  logic issue_done, owner;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] wdata;
  logic [OFS_W-1:0] issue_cnt, recv_cnt;
  logic issue_tc, recv_tc, issue_en, recv_en, last, in_fill, in_write, cnt_clr;
  assign in_fill = state == ST_FILL;
  assign in_write = state == ST_WRITE;
  assign issue_en = in_fill & ~issue_done;
  assign recv_en = in_fill & mem_data_valid;
  assign last = recv_en & recv_tc;
  assign cnt_clr = rst | ~in_fill | last;
  word_counter u_issue (.clk(clk), .clr(cnt_clr), .en(issue_en), .cnt(issue_cnt), .tc(issue_tc));
  word_counter u_recv (.clk(clk), .clr(cnt_clr), .en(recv_en), .cnt(recv_cnt), .tc(recv_tc));
  always_comb begin
    state_nx = state == ST_DRAIN ? (drain_cnt <= 3'd1 ? ST_IDLE : ST_DRAIN) :
               state == ST_IDLE  ? (d_req ? (d_wr ? ST_WRITE : ST_FILL) : (i_req ? ST_FILL : ST_IDLE)) :
               in_write          ? ST_IDLE :
               last              ? ST_IDLE : ST_FILL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_DRAIN;
      drain_cnt <= 3'(MEM_LATENCY);
      issue_done <= 1'b0;
      owner <= OWNER_I;
      base <= '0;
      wdata <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_DRAIN && drain_cnt != 3'd0) drain_cnt <= drain_cnt - 3'd1;
      // once all eight reads are issued, hold off further issues until the block returns
      issue_done <= in_fill & ~last & (issue_done | (issue_en & issue_tc));
      if (state == ST_IDLE) begin
        owner <= d_req ? OWNER_D : OWNER_I;
        base <= d_req ? d_addr : i_addr;
        wdata <= d_wdata;
      end
    end
  end
  assign busy = state != ST_IDLE;
  assign i_grant = in_fill & (owner == OWNER_I);
  assign d_grant = (in_fill & (owner == OWNER_D)) | in_write;
  assign i_done = last & (owner == OWNER_I);
  assign d_done = (last & (owner == OWNER_D)) | in_write;
  assign fill_valid = recv_en;
  assign fill_data = recv_en ? mem_data_out : '0;
  assign fill_word = recv_en ? recv_cnt : '0;
  assign fill_owner = recv_en & owner;
  assign mem_enable = issue_en | in_write;
  assign mem_wr = in_write;
  assign mem_addr = in_write ? base : issue_en ? {base[ADDR_W-1:OFS_W+1], issue_cnt, 1'b0} : '0;
  assign mem_data_in = in_write ? wdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of fills, stores, priority, reset drain and dropped requests.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic i_grant, d_grant, i_done, d_done, fill_valid, fill_owner, busy, mem_enable, mem_wr;
  logic [15:0] fill_data, mem_addr, mem_data_in, mem_data_out;
  logic [2:0] fill_word;
  logic mem_data_valid;
  logic [3:0] pv = '0;
  logic [15:0] pa [4];
  int checks = 0, errors = 0, stale = 0;
  always #5 clk = ~clk;
  mem_arbiter dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_wr(d_wr),
    .d_addr(d_addr), .d_wdata(d_wdata), .i_grant(i_grant), .d_grant(d_grant),
    .i_done(i_done), .d_done(d_done), .fill_valid(fill_valid), .fill_data(fill_data),
    .fill_word(fill_word), .fill_owner(fill_owner), .busy(busy), .mem_enable(mem_enable),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid)
  );
  // read issued in cycle c returns in cycle c+4; the memory ignores the arbiter's reset
  always @(posedge clk) begin
    pv <= {pv[2:0], mem_enable & ~mem_wr};
    pa[0] <= mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end
  assign mem_data_valid = pv[3];
  assign mem_data_out = pv[3] ? 16'hA000 + {13'd0, pa[3][3:1]} : 16'h0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // entered at the negedge of the first FILL cycle; leaves at the negedge of the done cycle
  task automatic run_fill(input logic own, input logic [15:0] base, input int drop_at);
    for (int j = 0; j < 12; j++) begin
      chk("fill_en", mem_enable, j < 8);
      chk("fill_wr", mem_wr, 0);
      if (j < 8) chk("fill_addr", mem_addr, (base & 16'hFFF0) | 16'(j * 2));
      chk("fill_valid", fill_valid, j >= 4);
      if (j >= 4) begin
        chk("fill_word", fill_word, j - 4);
        chk("fill_data", fill_data, 16'hA000 + 16'(j - 4));
        chk("fill_owner", fill_owner, own);
      end
      chk("i_grant", i_grant, own == 1'b0);
      chk("d_grant", d_grant, own == 1'b1);
      chk("i_done", i_done, j == 11 && own == 1'b0);
      chk("d_done", d_done, j == 11 && own == 1'b1);
      if (j == drop_at) begin
        if (own) d_req = 1'b0;
        else i_req = 1'b0;
      end
      if (j < 11) @(negedge clk);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_igrant"}, i_grant, 0);
    chk({tag, "_dgrant"}, d_grant, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_igrant", i_grant, 0);
    chk("rst_dgrant", d_grant, 0);
    chk("rst_en", mem_enable, 0);
    chk("rst_fv", fill_valid, 0);
    chk("rst_done", {i_done, d_done}, 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("drain_busy", busy, 1);
      @(negedge clk);
    end
    chk_idle("after_drain");
    // I fill of 0x1236
    i_req = 1'b1; i_addr = 16'h1236;
    chk("idle_no_grant", i_grant, 0);
    @(negedge clk);
    run_fill(1'b0, 16'h1230, 11);
    @(negedge clk);
    chk_idle("i_fill_end");
    // simultaneous D fill and I fill: D first
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h4000; i_req = 1'b1; i_addr = 16'h0010;
    @(negedge clk);
    run_fill(1'b1, 16'h4000, 11);
    @(negedge clk);
    chk_idle("between_fills");
    @(negedge clk);
    run_fill(1'b0, 16'h0010, 11);
    @(negedge clk);
    chk_idle("simul_end");
    // store
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h2002; d_wdata = 16'hBEEF;
    @(negedge clk);
    chk("st_en", mem_enable, 1);
    chk("st_wr", mem_wr, 1);
    chk("st_addr", mem_addr, 16'h2002);
    chk("st_data", mem_data_in, 16'hBEEF);
    chk("st_done", d_done, 1);
    chk("st_dgrant", d_grant, 1);
    chk("st_igrant", i_grant, 0);
    d_req = 1'b0;
    @(negedge clk);
    chk_idle("st_end");
    chk("st_en_off", mem_enable, 0);
    chk("st_done_off", d_done, 0);
    // I pending behind a store then a D fill
    i_req = 1'b1; i_addr = 16'h3000;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h2004; d_wdata = 16'h1234;
    @(negedge clk);
    chk("st2_addr", mem_addr, 16'h2004);
    chk("st2_data", mem_data_in, 16'h1234);
    chk("st2_igrant", i_grant, 0);
    d_wr = 1'b0; d_addr = 16'h5000;
    @(negedge clk);
    chk_idle("st2_end");
    @(negedge clk);
    run_fill(1'b1, 16'h5000, 11);
    @(negedge clk);
    chk_idle("pend_gap");
    @(negedge clk);
    run_fill(1'b0, 16'h3000, 11);
    @(negedge clk);
    chk_idle("pend_end");
    // reset mid-fill after the 5th issue
    i_req = 1'b1; i_addr = 16'h6000;
    @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      chk("pre_rst_en", mem_enable, 1);
      @(negedge clk);
    end
    rst = 1'b1; i_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_drop_igrant", i_grant, 0);
    chk("rst_drop_done", i_done, 0);
    for (int k = 0; k < 4; k++) begin
      chk("mid_drain_busy", busy, 1);
      chk("mid_drain_fv", fill_valid, 0);
      chk("mid_drain_en", mem_enable, 0);
      if (mem_data_valid) stale++;
      @(negedge clk);
    end
    chk("stale_seen", stale, 4);
    chk_idle("mid_rst_end");
    i_req = 1'b1; i_addr = 16'h7000;
    @(negedge clk);
    run_fill(1'b0, 16'h7000, 11);
    @(negedge clk);
    chk_idle("post_rst_fill");
    // dropped request after two issues still completes
    i_req = 1'b1; i_addr = 16'h8000;
    @(negedge clk);
    run_fill(1'b0, 16'h8000, 1);
    @(negedge clk);
    chk_idle("drop_end");
    @(negedge clk);
    chk_idle("drop_no_regrant");
    chk("drop_no_en", mem_enable, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
